uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter_if.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 156 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Shared-transmitter bus: per-requester byte streams on one side, the UART
// transmitter handshake and grant status on the other.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 cts;
    logic                 tx_busy;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 grant_active;
    logic [ID_W-1:0]      grant_id;
    logic                 ack_err;

    // Requesters plus transmitter side
    modport master (
        output req_valid, req_data, req_last, cts, tx_busy,
        input  req_ready, tx_start, tx_data, grant_active, grant_id, ack_err
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_data, req_last, cts, tx_busy,
        output req_ready, tx_start, tx_data, grant_active, grant_id, ack_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte
// requesters, with per-grant burst limit and transmitter acknowledge timeout.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | no owner; grant the round-robin winner once tx_busy is low
// SEND      | owner holds grant; start a byte when valid, cts and !tx_busy
// WAIT_ACK  | byte loaded; waiting for tx_busy to rise (timed)
// WAIT_DONE | byte serialising; on tx_busy fall continue or release
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int MAX_BURST   = 8,
    parameter int ACK_TIMEOUT = 4
) (
    input logic          clk,
    input logic          rst_n,
    uart_tx_arbiter_if.slave bus
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, WAIT_DONE} state_t;

    state_t           state_q, state_d;
    logic             grant_active_q, grant_active_d;
    logic [ID_W-1:0]  grant_id_q, grant_id_d;
    logic [ID_W-1:0]  last_owner_q, last_owner_d;
    logic [7:0]       burst_cnt_q, burst_cnt_d;
    logic             last_q, last_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             ack_err_q, ack_err_d;
    logic [7:0]       tx_data_q, tx_data_d;

    logic             win_found;
    logic [ID_W-1:0]  win_id;
    logic [ID_W-1:0]  cand;
    logic             own_valid;
    logic             own_last;
    logic [7:0]       own_data;
    logic             accept;

    // Round-robin search from last_owner+1; scanning backwards lets the
    // nearest valid requester overwrite farther ones.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = ID_W'((int'(last_owner_q) + i) % NUM_REQ);
            if (bus.req_valid[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    assign own_valid = bus.req_valid[grant_id_q];
    assign own_last  = bus.req_last[grant_id_q];
    assign own_data  = bus.req_data[{grant_id_q, 3'b000} +: 8];
    assign accept    = (state_q == SEND) && own_valid && bus.cts && !bus.tx_busy;

    // tx_start/req_ready complete the valid/ready handshake in the accept
    // cycle itself, so they decode the registered state with live inputs;
    // tx_data shows the accepted byte then holds it from tx_data_q.
    assign bus.tx_start     = accept;
    assign bus.req_ready    = accept ? (NUM_REQ'(1) << grant_id_q) : '0;
    assign bus.tx_data      = accept ? own_data : tx_data_q;
    assign bus.grant_active = grant_active_q;
    assign bus.grant_id     = grant_id_q;
    assign bus.ack_err      = ack_err_q;

    // Next-state and datapath update for the grant FSM
    always_comb begin
        state_d        = state_q;
        grant_active_d = grant_active_q;
        grant_id_d     = grant_id_q;
        last_owner_d   = last_owner_q;
        burst_cnt_d    = burst_cnt_q;
        last_d         = last_q;
        tmr_d          = tmr_q;
        ack_err_d      = ack_err_q;
        tx_data_d      = tx_data_q;
        case (state_q)
            IDLE: begin
                if (!bus.tx_busy && win_found) begin
                    grant_id_d     = win_id;
                    grant_active_d = 1'b1;
                    burst_cnt_d    = '0;
                    state_d        = SEND;
                end
            end
            SEND: begin
                if (!own_valid) begin
                    state_d        = IDLE;
                    grant_active_d = 1'b0;
                    last_owner_d   = grant_id_q;
                end else if (bus.cts && !bus.tx_busy) begin
                    tx_data_d   = own_data;
                    burst_cnt_d = (burst_cnt_q == 8'hFF) ? burst_cnt_q : burst_cnt_q + 8'd1;
                    last_d      = own_last;
                    tmr_d       = TMR_W'(ACK_TIMEOUT - 1);
                    state_d     = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (bus.tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (tmr_q == '0) begin
                    ack_err_d      = 1'b1;
                    state_d        = IDLE;
                    grant_active_d = 1'b0;
                    last_owner_d   = grant_id_q;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    if (last_q || (burst_cnt_q >= 8'(MAX_BURST))) begin
                        state_d        = IDLE;
                        grant_active_d = 1'b0;
                        last_owner_d   = grant_id_q;
                    end else begin
                        state_d = SEND;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; last_owner resets to the top index so requester 0 wins first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            grant_active_q <= 1'b0;
            grant_id_q     <= '0;
            last_owner_q   <= ID_W'(NUM_REQ - 1);
            burst_cnt_q    <= '0;
            last_q         <= 1'b0;
            tmr_q          <= '0;
            ack_err_q      <= 1'b0;
            tx_data_q      <= 8'h00;
        end else begin
            state_q        <= state_d;
            grant_active_q <= grant_active_d;
            grant_id_q     <= grant_id_d;
            last_owner_q   <= last_owner_d;
            burst_cnt_q    <= burst_cnt_d;
            last_q         <= last_d;
            tmr_q          <= tmr_d;
            ack_err_q      <= ack_err_d;
            tx_data_q      <= tx_data_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: queue-driven requesters, a simple
// transmitter model, and a log of every tx_start for ordering checks.
module tb_uart_tx_arbiter;
    localparam int NREQ = 4;
    localparam int ATO  = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(NREQ)) bus ();

    uart_tx_arbiter #(.NUM_REQ(NREQ), .MAX_BURST(8), .ACK_TIMEOUT(ATO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    logic [8:0]      rq [NREQ][$];
    logic [11:0]     log_q[$];
    logic [11:0]     expq[$];
    logic [NREQ-1:0] rdy_s = '0;
    logic            start_s = 1'b0;
    logic            ga_prev = 1'b0;
    int              ngrant = 0;
    int              bad_onehot = 0;
    int              bad_pair = 0;
    int              busy_cnt = 0;
    int              busy_len = 3;
    logic            tx_en = 1'b1;
    logic [NREQ-1:0]   v;
    logic [8*NREQ-1:0] d;
    logic [NREQ-1:0]   l;

    // Sample outputs mid-cycle and log every started byte
    always @(negedge clk) begin
        start_s = bus.tx_start;
        rdy_s   = bus.req_ready;
        if (bus.tx_start)
            log_q.push_back({bus.tx_busy, 3'(bus.grant_id), bus.tx_data});
        if ($countones(rdy_s) > 1) bad_onehot++;
        if (bus.tx_start !== (rdy_s != '0)) bad_pair++;
        if (bus.grant_active && !ga_prev) ngrant++;
        ga_prev = bus.grant_active;
    end

    // Requester queues and transmitter model, updated just after each edge
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NREQ; i++)
            if (rdy_s[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        if (busy_cnt > 0) busy_cnt--;
        if (start_s && tx_en) busy_cnt = busy_len;
        bus.tx_busy = (busy_cnt > 0);
        v = '0; d = '0; l = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (rq[i].size() > 0) begin
                v[i]         = 1'b1;
                d[8*i +: 8]  = rq[i][0][7:0];
                l[i]         = rq[i][0][8];
            end
        end
        bus.req_valid = v;
        bus.req_data  = d;
        bus.req_last  = l;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] ent(input int i);
        return (i < log_q.size()) ? log_q[i] : 12'hFFF;
    endfunction

    function automatic logic [11:0] mk(input int g, input logic [7:0] b);
        return {1'b0, 3'(g), b};
    endfunction

    initial begin
        rst_n   = 1'b0;
        bus.cts = 1'b1;
        tick(3);
        check("rst_grant_active", bus.grant_active, 0);
        check("rst_grant_id", bus.grant_id, 0);
        check("rst_ack_err", bus.ack_err, 0);
        check("rst_tx_start", bus.tx_start, 0);
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_tx_data", bus.tx_data, 8'h00);
        rst_n = 1'b1;

        // Single requester, three bytes, slow transmitter
        busy_len = 160;
        rq[0].push_back({1'b0, 8'hA5});
        rq[0].push_back({1'b0, 8'h5A});
        rq[0].push_back({1'b1, 8'hFF});
        for (int k = 0; k < 1200 && !(log_q.size() >= 3 && !bus.grant_active); k++) @(negedge clk);
        check("single_count", log_q.size(), 3);
        check("single_b0", ent(0), mk(0, 8'hA5));
        check("single_b1", ent(1), mk(0, 8'h5A));
        check("single_b2", ent(2), mk(0, 8'hFF));
        check("single_released", bus.grant_active, 0);
        check("single_data_hold", bus.tx_data, 8'hFF);

        // All four valid, last on every byte: one byte per grant, 0,1,2,3,...
        tick(1);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        log_q.delete();
        ngrant   = 0;
        busy_len = 3;
        for (int j = 0; j < 2; j++)
            for (int i = 0; i < NREQ; i++) rq[i].push_back({1'b1, 8'(16 * i + j)});
        for (int k = 0; k < 600 && !(log_q.size() >= 8 && !bus.grant_active); k++) @(negedge clk);
        check("rr_count", log_q.size(), 8);
        check("rr_grants", ngrant, 8);
        for (int n = 0; n < 8; n++)
            check($sformatf("rr_seq[%0d]", n), ent(n), mk(n % 4, 8'(16 * (n % 4) + n / 4)));

        // Requester 2 streams 20 bytes with no last; requester 3 interleaves
        log_q.delete();
        ngrant = 0;
        expq.delete();
        for (int k = 0; k < 20; k++) rq[2].push_back({1'b0, 8'(8'h40 + k)});
        rq[3].push_back({1'b1, 8'h77});
        rq[3].push_back({1'b1, 8'h78});
        for (int k = 0; k < 8; k++)  expq.push_back(mk(2, 8'(8'h40 + k)));
        expq.push_back(mk(3, 8'h77));
        for (int k = 8; k < 16; k++) expq.push_back(mk(2, 8'(8'h40 + k)));
        expq.push_back(mk(3, 8'h78));
        for (int k = 16; k < 20; k++) expq.push_back(mk(2, 8'(8'h40 + k)));
        for (int k = 0; k < 2000 && !(log_q.size() >= 22 && !bus.grant_active); k++) @(negedge clk);
        check("burst_count", log_q.size(), 22);
        check("burst_grants", ngrant, 5);
        for (int n = 0; n < 22; n++)
            check($sformatf("burst_seq[%0d]", n), ent(n), expq[n]);

        // cts low holds the grant without starting
        log_q.delete();
        bus.cts = 1'b0;
        rq[1].push_back({1'b1, 8'h3C});
        tick(500);
        @(negedge clk);
        check("cts_no_start", log_q.size(), 0);
        check("cts_grant_held", bus.grant_active, 1);
        check("cts_grant_id", bus.grant_id, 1);
        @(posedge clk);
        #1;
        bus.cts = 1'b1;
        @(negedge clk);
        check("cts_start", bus.tx_start, 1);
        check("cts_data", bus.tx_data, 8'h3C);
        check("cts_ready", bus.req_ready, 4'b0010);
        for (int k = 0; k < 100 && !(log_q.size() >= 1 && !bus.grant_active); k++) @(negedge clk);
        check("cts_done", log_q.size(), 1);

        // Transmitter never acknowledges
        log_q.delete();
        tx_en = 1'b0;
        rq[3].push_back({1'b1, 8'h99});
        for (int k = 0; k < 100 && !bus.tx_start; k++) @(negedge clk);
        check("ato_start", bus.tx_start, 1);
        check("ato_owner", bus.grant_id, 3);
        repeat (ATO) @(negedge clk);
        check("ato_err_not_yet", bus.ack_err, 0);
        check("ato_grant_still", bus.grant_active, 1);
        @(negedge clk);
        check("ato_err_set", bus.ack_err, 1);
        check("ato_released", bus.grant_active, 0);

        // ack_err is sticky across normal traffic
        log_q.delete();
        tx_en = 1'b1;
        rq[0].push_back({1'b1, 8'h11});
        for (int k = 0; k < 100 && !(log_q.size() >= 1 && !bus.grant_active); k++) @(negedge clk);
        check("sticky_byte", ent(0), mk(0, 8'h11));
        check("sticky_err", bus.ack_err, 1);

        // Reset mid-byte while requesters 0 and 1 wait
        log_q.delete();
        busy_len = 50;
        rq[2].push_back({1'b1, 8'h22});
        for (int k = 0; k < 100 && log_q.size() < 1; k++) @(negedge clk);
        check("mid_owner", ent(0), mk(2, 8'h22));
        tick(10);
        rq[0].push_back({1'b1, 8'hAB});
        rq[1].push_back({1'b1, 8'hCD});
        tick(2);
        check("mid_grant_kept", bus.grant_id, 2);
        check("mid_active_kept", bus.grant_active, 1);
        rst_n = 1'b0;
        #2;
        check("arst_grant_active", bus.grant_active, 0);
        check("arst_grant_id", bus.grant_id, 0);
        check("arst_ack_err", bus.ack_err, 0);
        check("arst_tx_start", bus.tx_start, 0);
        check("arst_req_ready", bus.req_ready, 0);
        check("arst_tx_data", bus.tx_data, 8'h00);
        tick(2);
        rst_n = 1'b1;
        tick(3);
        check("arst_wait_busy", bus.grant_active, 0);
        for (int k = 0; k < 200 && log_q.size() < 2; k++) @(negedge clk);
        check("arst_first_grant", ent(1), mk(0, 8'hAB));
        for (int k = 0; k < 200 && !(log_q.size() >= 3 && !bus.grant_active); k++) @(negedge clk);
        check("arst_second_grant", ent(2), mk(1, 8'hCD));

        check("ready_onehot", bad_onehot, 0);
        check("ready_with_start", bad_pair, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
